event_sync_multi: RTL and testbench

//  Parametrised multi-channel synchroniser for asynchronous status/event lines
//  (finish, done, error flags) entering the clk domain. Per channel it provides
//  an N-stage metastability chain, an optional stability (glitch) filter,

---
 rtl/event_sync_multi_pkg.sv | 11 +
 rtl/event_sync_multi_sync_chain.sv | 42 ++++
 rtl/event_sync_multi.sv | 116 +++++++++++
 tb/tb_event_sync_multi.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/event_sync_multi_pkg.sv
// Shared synchroniser parameters.
//   SYNC_DEFAULT_STAGES        default flop count of each synchroniser chain
//   SYNC_DEFAULT_FILTER_CYCLES default stability filter length (0 = no filter)
//   SYNC_MIN_STAGES            smallest chain length accepted at elaboration
package event_sync_multi_pkg;

    localparam int unsigned SYNC_DEFAULT_STAGES        = 2;
    localparam int unsigned SYNC_DEFAULT_FILTER_CYCLES = 0;
    localparam int unsigned SYNC_MIN_STAGES            = 2;

endpackage

// File: rtl/event_sync_multi_sync_chain.sv
// Plain multi-flop synchroniser chain. The only place metastable flops live,
// so CDC waivers can be scoped to this module.
// Ports:
//   clk    in   1      destination-domain clock
//   rst_n  in   1      asynchronous, active-low reset (flops go to RESET_LEVEL)
//   d      in   WIDTH  asynchronous input
//   q      out  WIDTH  synchronised output (last stage)
module event_sync_multi_sync_chain
    import event_sync_multi_pkg::*;
#(
    parameter int unsigned WIDTH       = 1,
    parameter int unsigned STAGES      = SYNC_DEFAULT_STAGES,
    parameter logic        RESET_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    if (STAGES < SYNC_MIN_STAGES) begin : g_bad_stages
        $error("event_sync_multi_sync_chain: STAGES must be at least %0d", SYNC_MIN_STAGES);
    end

    logic [WIDTH-1:0] stage_q [STAGES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < int'(STAGES); k++) begin
                stage_q[k] <= {WIDTH{RESET_LEVEL}};
            end
        end else begin
            stage_q[0] <= d;
            for (int k = 1; k < int'(STAGES); k++) begin
                stage_q[k] <= stage_q[k-1];
            end
        end
    end

    assign q = stage_q[STAGES-1];

endmodule

// File: rtl/event_sync_multi.sv
// Multi-channel synchroniser for asynchronous status/event lines. Each channel
// has its own synchroniser chain, optional stability filter, registered
// rise/fall pulse detection and a sticky event flag with per-channel clear.
// Ports:
//   clk         in   1       destination-domain clock
//   rst_n       in   1       asynchronous, active-low reset
//   async_in    in   NUM_CH  asynchronous inputs, one bit per channel
//   sticky_clr  in   NUM_CH  per-channel sticky clear (synchronous to clk)
//   level_out   out  NUM_CH  synchronised (and filtered) level
//   rise_pulse  out  NUM_CH  1-cycle pulse on level_out 0->1
//   fall_pulse  out  NUM_CH  1-cycle pulse on level_out 1->0
//   sticky      out  NUM_CH  set by a rise, held until sticky_clr
//   any_sticky  out  1       OR of all sticky flags
module event_sync_multi
    import event_sync_multi_pkg::*;
#(
    parameter int unsigned NUM_CH        = 4,
    parameter int unsigned SYNC_STAGES   = SYNC_DEFAULT_STAGES,
    parameter int unsigned FILTER_CYCLES = SYNC_DEFAULT_FILTER_CYCLES,
    parameter logic        RESET_LEVEL   = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] async_in,
    input  logic [NUM_CH-1:0] sticky_clr,
    output logic [NUM_CH-1:0] level_out,
    output logic [NUM_CH-1:0] rise_pulse,
    output logic [NUM_CH-1:0] fall_pulse,
    output logic [NUM_CH-1:0] sticky,
    output logic              any_sticky
);

    if (SYNC_STAGES < SYNC_MIN_STAGES) begin : g_bad_stages
        $error("event_sync_multi: SYNC_STAGES must be at least %0d", SYNC_MIN_STAGES);
    end
    if (NUM_CH < 1) begin : g_bad_num_ch
        $error("event_sync_multi: NUM_CH must be at least 1");
    end

    for (genvar i = 0; i < int'(NUM_CH); i++) begin : g_ch
        logic synced;
        logic level_d, level_q;
        logic rise_d;
        logic rise_q, fall_q, sticky_q;

        event_sync_multi_sync_chain #(
            .WIDTH       (1),
            .STAGES      (SYNC_STAGES),
            .RESET_LEVEL (RESET_LEVEL)
        ) u_sync_chain (
            .clk   (clk),
            .rst_n (rst_n),
            .d     (async_in[i]),
            .q     (synced)
        );

        if (FILTER_CYCLES == 0) begin : g_no_filter
            assign level_d = synced;
        end else begin : g_filter
            localparam int unsigned CW = $clog2(FILTER_CYCLES + 1);
            localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_CYCLES - 1);

            logic [CW-1:0] cnt_d, cnt_q;

            // The first cycle of disagreement counts as cycle one, so the level
            // follows on the FILTER_CYCLES-th consecutive disagreeing cycle.
            always_comb begin
                level_d = level_q;
                cnt_d   = cnt_q;
                if (synced == level_q) begin
                    cnt_d = '0;
                end else if (cnt_q == CNT_LAST) begin
                    level_d = synced;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end
        end

        // Pulses are computed from the next level so they line up with the
        // first cycle level_out shows its new value.
        assign rise_d = level_d & ~level_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                level_q  <= RESET_LEVEL;
                rise_q   <= 1'b0;
                fall_q   <= 1'b0;
                sticky_q <= 1'b0;
            end else begin
                level_q  <= level_d;
                rise_q   <= rise_d;
                fall_q   <= ~level_d & level_q;
                // A new rise wins over a clear in the same cycle.
                sticky_q <= (sticky_q & ~sticky_clr[i]) | rise_d;
            end
        end

        assign level_out[i]  = level_q;
        assign rise_pulse[i] = rise_q;
        assign fall_pulse[i] = fall_q;
        assign sticky[i]     = sticky_q;
    end

    assign any_sticky = |sticky;

endmodule

// File: tb/tb_event_sync_multi.sv
// Bench for event_sync_multi. Three instances share one stimulus stream:
//   dut0: SYNC_STAGES=2, FILTER_CYCLES=0
//   dut1: SYNC_STAGES=2, FILTER_CYCLES=3
//   dut2: SYNC_STAGES=4, FILTER_CYCLES=2
// A cycle model checks every instance after every edge; a vector table and
// hand-written sequences check specific behaviour against fixed values.
module tb_event_sync_multi;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic [3:0] async_in = 4'b0000;
    logic [3:0] sticky_clr = 4'b0000;

    logic [2:0][3:0] d_lvl, d_rise, d_fall, d_stk;
    logic [2:0]      d_any;

    always #5 clk = ~clk;

    event_sync_multi #(
        .NUM_CH(4), .SYNC_STAGES(2), .FILTER_CYCLES(0), .RESET_LEVEL(1'b0)
    ) dut0 (
        .clk(clk), .rst_n(rst_n), .async_in(async_in), .sticky_clr(sticky_clr),
        .level_out(d_lvl[0]), .rise_pulse(d_rise[0]), .fall_pulse(d_fall[0]),
        .sticky(d_stk[0]), .any_sticky(d_any[0])
    );

    event_sync_multi #(
        .NUM_CH(4), .SYNC_STAGES(2), .FILTER_CYCLES(3), .RESET_LEVEL(1'b0)
    ) dut1 (
        .clk(clk), .rst_n(rst_n), .async_in(async_in), .sticky_clr(sticky_clr),
        .level_out(d_lvl[1]), .rise_pulse(d_rise[1]), .fall_pulse(d_fall[1]),
        .sticky(d_stk[1]), .any_sticky(d_any[1])
    );

    event_sync_multi #(
        .NUM_CH(4), .SYNC_STAGES(4), .FILTER_CYCLES(2), .RESET_LEVEL(1'b0)
    ) dut2 (
        .clk(clk), .rst_n(rst_n), .async_in(async_in), .sticky_clr(sticky_clr),
        .level_out(d_lvl[2]), .rise_pulse(d_rise[2]), .fall_pulse(d_fall[2]),
        .sticky(d_stk[2]), .any_sticky(d_any[2])
    );

    int n_checks = 0;
    int n_fail   = 0;

    int st [3];
    int fl [3];

    // Reference model state, one set per instance.
    logic [3:0] m_s    [3][4];
    logic [3:0] m_lvl  [3];
    logic [3:0] m_rise [3];
    logic [3:0] m_fall [3];
    logic [3:0] m_stk  [3];
    int         m_cnt  [3][4];

    typedef struct {
        logic [3:0] a;
        logic [3:0] clr;
        logic [3:0] lvl;
        logic [3:0] rise;
        logic [3:0] fall;
        logic [3:0] stk;
        logic       any;
    } vec_t;

    vec_t tbl [23];
    vec_t exp_q [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 3; d++) begin
            for (int k = 0; k < 4; k++) begin
                m_s[d][k]   = 4'b0000;
                m_cnt[d][k] = 0;
            end
            m_lvl[d]  = 4'b0000;
            m_rise[d] = 4'b0000;
            m_fall[d] = 4'b0000;
            m_stk[d]  = 4'b0000;
        end
    endtask

    // Advance the model by one clock edge using the inputs the DUT sampled.
    task automatic model_step();
        logic [3:0] syn;
        logic [3:0] nxt;
        if (!rst_n) return;
        for (int d = 0; d < 3; d++) begin
            syn = m_s[d][st[d]-1];
            nxt = m_lvl[d];
            for (int c = 0; c < 4; c++) begin
                if (fl[d] == 0) begin
                    nxt[c] = syn[c];
                end else if (syn[c] == m_lvl[d][c]) begin
                    m_cnt[d][c] = 0;
                end else if (m_cnt[d][c] == fl[d] - 1) begin
                    nxt[c] = syn[c];
                    m_cnt[d][c] = 0;
                end else begin
                    m_cnt[d][c] = m_cnt[d][c] + 1;
                end
            end
            m_rise[d] = nxt & ~m_lvl[d];
            m_fall[d] = ~nxt & m_lvl[d];
            m_stk[d]  = (m_stk[d] & ~sticky_clr) | m_rise[d];
            m_lvl[d]  = nxt;
            for (int k = 3; k > 0; k--) m_s[d][k] = m_s[d][k-1];
            m_s[d][0] = async_in;
        end
    endtask

    task automatic compare_model();
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("dut%0d level", d), 32'(d_lvl[d]), 32'(m_lvl[d]));
            chk($sformatf("dut%0d rise", d), 32'(d_rise[d]), 32'(m_rise[d]));
            chk($sformatf("dut%0d fall", d), 32'(d_fall[d]), 32'(m_fall[d]));
            chk($sformatf("dut%0d sticky", d), 32'(d_stk[d]), 32'(m_stk[d]));
            chk($sformatf("dut%0d any_sticky", d), 32'(d_any[d]), 32'(|m_stk[d]));
            chk($sformatf("dut%0d rise&fall", d), 32'(d_rise[d] & d_fall[d]), 32'd0);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        compare_model();
    endtask

    task automatic do_reset();
        async_in   = 4'b0000;
        sticky_clr = 4'b0000;
        rst_n      = 1'b0;
        model_reset();
        #1;
        compare_model();
        repeat (2) tick();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int edges;
        logic seen;
        vec_t e;

        st[0] = 2; fl[0] = 0;
        st[1] = 2; fl[1] = 3;
        st[2] = 4; fl[2] = 2;

        //            async    clr      level    rise     fall     sticky   any
        tbl[0]  = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0};
        tbl[1]  = '{4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0};
        tbl[2]  = '{4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0};
        tbl[3]  = '{4'b0100, 4'b0000, 4'b0100, 4'b0100, 4'b0000, 4'b0100, 1'b1};
        tbl[4]  = '{4'b0100, 4'b0000, 4'b0100, 4'b0000, 4'b0000, 4'b0100, 1'b1};
        tbl[5]  = '{4'b0110, 4'b0000, 4'b0100, 4'b0000, 4'b0000, 4'b0100, 1'b1};
        tbl[6]  = '{4'b0110, 4'b0000, 4'b0100, 4'b0000, 4'b0000, 4'b0100, 1'b1};
        tbl[7]  = '{4'b0110, 4'b0000, 4'b0110, 4'b0010, 4'b0000, 4'b0110, 1'b1};
        tbl[8]  = '{4'b0100, 4'b0000, 4'b0110, 4'b0000, 4'b0000, 4'b0110, 1'b1};
        tbl[9]  = '{4'b0100, 4'b0000, 4'b0110, 4'b0000, 4'b0000, 4'b0110, 1'b1};
        tbl[10] = '{4'b0100, 4'b0000, 4'b0100, 4'b0000, 4'b0010, 4'b0110, 1'b1};
        tbl[11] = '{4'b0110, 4'b0000, 4'b0100, 4'b0000, 4'b0000, 4'b0110, 1'b1};
        tbl[12] = '{4'b0110, 4'b0000, 4'b0100, 4'b0000, 4'b0000, 4'b0110, 1'b1};
        // Clear of ch1 in the same cycle as its new rise: sticky must stay set.
        tbl[13] = '{4'b0110, 4'b0010, 4'b0110, 4'b0010, 4'b0000, 4'b0110, 1'b1};
        tbl[14] = '{4'b0110, 4'b0110, 4'b0110, 4'b0000, 4'b0000, 4'b0000, 1'b0};
        // Clear with nothing pending is a no-op.
        tbl[15] = '{4'b0110, 4'b0100, 4'b0110, 4'b0000, 4'b0000, 4'b0000, 1'b0};
        tbl[16] = '{4'b1110, 4'b0000, 4'b0110, 4'b0000, 4'b0000, 4'b0000, 1'b0};
        tbl[17] = '{4'b1110, 4'b0000, 4'b0110, 4'b0000, 4'b0000, 4'b0000, 1'b0};
        tbl[18] = '{4'b1110, 4'b0000, 4'b1110, 4'b1000, 4'b0000, 4'b1000, 1'b1};
        tbl[19] = '{4'b0110, 4'b0000, 4'b1110, 4'b0000, 4'b0000, 4'b1000, 1'b1};
        tbl[20] = '{4'b0110, 4'b0000, 4'b1110, 4'b0000, 4'b0000, 4'b1000, 1'b1};
        // Sticky survives the fall until explicitly cleared.
        tbl[21] = '{4'b0110, 4'b0000, 4'b0110, 4'b0000, 4'b1000, 4'b1000, 1'b1};
        tbl[22] = '{4'b0110, 4'b1000, 4'b0110, 4'b0000, 4'b0000, 4'b0000, 1'b0};

        #2;
        do_reset();

        // Table on dut0 (2 stages, no filter).
        for (int i = 0; i < 23; i++) begin
            async_in   = tbl[i].a;
            sticky_clr = tbl[i].clr;
            exp_q.push_back(tbl[i]);
            tick();
            e = exp_q.pop_front();
            chk($sformatf("row%0d level", i), 32'(d_lvl[0]), 32'(e.lvl));
            chk($sformatf("row%0d rise", i), 32'(d_rise[0]), 32'(e.rise));
            chk($sformatf("row%0d fall", i), 32'(d_fall[0]), 32'(e.fall));
            chk($sformatf("row%0d sticky", i), 32'(d_stk[0]), 32'(e.stk));
            chk($sformatf("row%0d any_sticky", i), 32'(d_any[0]), 32'(e.any));
        end
        sticky_clr = 4'b0000;

        // Glitch filter on dut1 (3 cycles): a 2-cycle pulse must not get through.
        do_reset();
        seen = 1'b0;
        async_in = 4'b0001;
        repeat (2) begin tick(); seen = seen | d_rise[1][0] | d_lvl[1][0]; end
        async_in = 4'b0000;
        repeat (8) begin tick(); seen = seen | d_rise[1][0] | d_lvl[1][0]; end
        chk("glitch reached dut1 level/rise", 32'(seen), 32'd0);
        chk("glitch set dut1 sticky", 32'(d_stk[1][0]), 32'd0);

        // Sustained high: 2 chain edges, then 3 disagreeing cycles.
        async_in = 4'b0001;
        edges = 0;
        while (d_lvl[1][0] !== 1'b1 && edges < 20) begin
            tick();
            edges++;
        end
        chk("dut1 filtered rise latency", 32'(edges), 32'd5);
        chk("dut1 rise pulse on first high cycle", 32'(d_rise[1][0]), 32'd1);
        chk("dut1 sticky after rise", 32'(d_stk[1][0]), 32'd1);
        tick();
        chk("dut1 rise pulse one cycle only", 32'(d_rise[1][0]), 32'd0);

        async_in = 4'b0000;
        repeat (10) tick();

        // Reset in the middle of a filter count with the input held high.
        async_in = 4'b0001;
        repeat (3) tick();
        rst_n = 1'b0;
        model_reset();
        #1;
        compare_model();
        chk("mid-count reset dut1 level", 32'(d_lvl[1]), 32'd0);
        chk("mid-count reset dut0 sticky", 32'(d_stk[0]), 32'd0);
        chk("mid-count reset any_sticky", 32'(d_any), 32'd0);
        repeat (2) tick();
        @(negedge clk);
        rst_n = 1'b1;
        edges = 0;
        while (d_rise[0][0] !== 1'b1 && edges < 10) begin
            tick();
            edges++;
        end
        chk("dut0 rise latency after reset release", 32'(edges), 32'd3);
        repeat (4) tick();
        chk("dut1 level after reset release", 32'(d_lvl[1][0]), 32'd1);

        // Random toggles on all channels, checked every cycle by the model.
        for (int n = 0; n < 600; n++) begin
            for (int c = 0; c < 4; c++) begin
                if ($urandom_range(0, 3) == 0) async_in[c] = ~async_in[c];
                sticky_clr[c] = ($urandom_range(0, 7) == 0);
            end
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
